// File: rtl/vga_timing_monitor.sv
// Sink-side VGA timing monitor: measures line/frame lengths, tracks lock and recovers
// the visible-pixel coordinates from sampled hsync/vsync.
module vga_timing_monitor #(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BP        = 48,
  parameter int unsigned H_TOTAL     = 800,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BP        = 33,
  parameter int unsigned V_TOTAL     = 525,
  parameter bit          SYNC_POL    = 1'b0,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pixel_ce,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic [2:0] pixel_in,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       pixel_valid,
  output logic [2:0] pixel_out,
  output logic       frame_start,
  output logic       locked,
  output logic       timing_err,
  output logic [9:0] h_meas,
  output logic [9:0] v_meas
);

  localparam logic [9:0] HStart  = 10'(H_SYNC + H_BP);
  localparam logic [9:0] HEnd    = 10'(H_SYNC + H_BP + H_ACTIVE - 1);
  localparam logic [9:0] VStart  = 10'(V_SYNC + V_BP);
  localparam logic [9:0] VEnd    = 10'(V_SYNC + V_BP + V_ACTIVE - 1);
  localparam logic [9:0] HTot    = 10'(H_TOTAL);
  localparam logic [9:0] VTot    = 10'(V_TOTAL);
  localparam logic [9:0] CntMax  = 10'h3ff;
  localparam logic [2:0] LockCnt = 3'(LOCK_FRAMES);

  typedef enum logic [1:0] {StSearch, StTrack, StLocked} state_e;

  state_e     state_q, state_d;
  logic       hs_q, vs_q;
  logic [9:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic [9:0] h_inc, v_inc;
  logic       h_armed_q, h_armed_d, v_armed_q, v_armed_d;
  logic [2:0] good_q, good_d, good_inc;
  logic       hs_edge, vs_edge, err, active;

  always_comb begin
    hs_edge  = pixel_ce && (hsync_in == SYNC_POL) && (hs_q != SYNC_POL);
    vs_edge  = pixel_ce && (vsync_in == SYNC_POL) && (vs_q != SYNC_POL);
    // Saturating increments double as the measured length on an edge.
    h_inc    = (h_cnt_q == CntMax) ? CntMax : h_cnt_q + 10'd1;
    v_inc    = (v_cnt_q == CntMax) ? CntMax : v_cnt_q + 10'd1;
    h_cnt_d  = hs_edge ? 10'd0 : h_inc;
    v_cnt_d  = vs_edge ? 10'd0 : (hs_edge ? v_inc : v_cnt_q);
    err      = (hs_edge && h_armed_q && (h_inc != HTot)) ||
               (vs_edge && v_armed_q && (v_inc != VTot));
    good_inc = good_q + 3'd1;

    state_d = state_q;
    good_d  = good_q;
    if (err) begin
      state_d = StSearch;
      good_d  = 3'd0;
    end else if (vs_edge) begin
      unique case (state_q)
        StSearch: begin
          state_d = StTrack;
          good_d  = 3'd0;
        end
        StTrack: begin
          if (good_inc >= LockCnt) state_d = StLocked;
          else                     good_d  = good_inc;
        end
        default: state_d = state_q;
      endcase
    end

    // Any error re-enters search, so the next edge of each sync only restarts counting.
    h_armed_d = err ? 1'b0 : (h_armed_q | hs_edge);
    v_armed_d = err ? 1'b0 : (v_armed_q | vs_edge);

    active = (state_d == StLocked) && (h_cnt_d >= HStart) && (h_cnt_d <= HEnd) &&
             (v_cnt_d >= VStart) && (v_cnt_d <= VEnd);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StSearch;
      hs_q        <= ~SYNC_POL;
      vs_q        <= ~SYNC_POL;
      h_cnt_q     <= '0;
      v_cnt_q     <= '0;
      h_armed_q   <= 1'b0;
      v_armed_q   <= 1'b0;
      good_q      <= '0;
      x           <= '0;
      y           <= '0;
      pixel_valid <= 1'b0;
      pixel_out   <= '0;
      frame_start <= 1'b0;
      locked      <= 1'b0;
      timing_err  <= 1'b0;
      h_meas      <= '0;
      v_meas      <= '0;
    end else if (pixel_ce) begin
      state_q     <= state_d;
      hs_q        <= hsync_in;
      vs_q        <= vsync_in;
      h_cnt_q     <= h_cnt_d;
      v_cnt_q     <= v_cnt_d;
      h_armed_q   <= h_armed_d;
      v_armed_q   <= v_armed_d;
      good_q      <= good_d;
      pixel_valid <= active;
      pixel_out   <= pixel_in;
      frame_start <= active && (h_cnt_d == HStart) && (v_cnt_d == VStart);
      locked      <= (state_d == StLocked);
      timing_err  <= err;
      if (active) begin
        x <= h_cnt_d - HStart;
        y <= v_cnt_d - VStart;
      end
      if (hs_edge && h_armed_q) h_meas <= h_inc;
      if (vs_edge && v_armed_q) v_meas <= v_inc;
    end else begin
      pixel_valid <= 1'b0;
      frame_start <= 1'b0;
      timing_err  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_timing_monitor.sv
// Randomized bench for vga_timing_monitor on a scaled-down raster, both sync polarities,
// checked every clock against an event-level reference model.
module tb_vga_timing_monitor;

  localparam int HA = 16, HS = 4, HB = 4, HT = 32;
  localparam int VA = 8, VS = 2, VB = 3, VT = 16;
  localparam int LF = 2;
  localparam int HOFF = HS + HB, VOFF = VS + VB;

  logic clk = 1'b0, rst_n = 1'b1, pixel_ce = 1'b0;
  logic hsync = 1'b1, vsync = 1'b1;
  logic [2:0] pixel = '0;

  logic [9:0] a_x, a_y, a_hm, a_vm, b_x, b_y, b_hm, b_vm;
  logic [2:0] a_pix, b_pix;
  logic a_pv, a_fs, a_lock, a_err, b_pv, b_fs, b_lock, b_err;

  vga_timing_monitor #(
    .H_ACTIVE(HA), .H_SYNC(HS), .H_BP(HB), .H_TOTAL(HT),
    .V_ACTIVE(VA), .V_SYNC(VS), .V_BP(VB), .V_TOTAL(VT),
    .SYNC_POL(1'b0), .LOCK_FRAMES(LF)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .pixel_ce(pixel_ce), .hsync_in(hsync), .vsync_in(vsync),
    .pixel_in(pixel), .x(a_x), .y(a_y), .pixel_valid(a_pv), .pixel_out(a_pix),
    .frame_start(a_fs), .locked(a_lock), .timing_err(a_err), .h_meas(a_hm), .v_meas(a_vm)
  );

  vga_timing_monitor #(
    .H_ACTIVE(HA), .H_SYNC(HS), .H_BP(HB), .H_TOTAL(HT),
    .V_ACTIVE(VA), .V_SYNC(VS), .V_BP(VB), .V_TOTAL(VT),
    .SYNC_POL(1'b1), .LOCK_FRAMES(LF)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .pixel_ce(pixel_ce), .hsync_in(~hsync), .vsync_in(~vsync),
    .pixel_in(pixel), .x(b_x), .y(b_y), .pixel_valid(b_pv), .pixel_out(b_pix),
    .frame_start(b_fs), .locked(b_lock), .timing_err(b_err), .h_meas(b_hm), .v_meas(b_vm)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_bad = 0;
  int err_pulses = 0, fs_seen = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: sync levels seen as "asserted", lengths from sample indices.
  int m_idx, m_last_h, m_lines, m_st, m_good;
  bit m_have_h, m_have_v, m_hs_prev, m_vs_prev;
  logic [9:0] e_x, e_y, e_hm, e_vm;
  logic [2:0] e_pix;
  logic e_pv, e_fs, e_lock, e_err;

  function automatic int sat(input int v);
    return (v > 1023) ? 1023 : v;
  endfunction

  task automatic model_reset();
    m_idx = 0; m_last_h = 0; m_lines = 0; m_st = 0; m_good = 0;
    m_have_h = 0; m_have_v = 0; m_hs_prev = 0; m_vs_prev = 0;
    e_x = '0; e_y = '0; e_hm = '0; e_vm = '0; e_pix = '0;
    e_pv = 0; e_fs = 0; e_lock = 0; e_err = 0;
  endtask

  task automatic model_update(input bit ce);
    int hc, vc, hm, vm;
    bit hs, vs, he, ve, err;
    if (!ce) begin
      e_pv = 0; e_fs = 0; e_err = 0;
      return;
    end
    hs = (hsync == 1'b0);
    vs = (vsync == 1'b0);
    he = hs && !m_hs_prev;
    ve = vs && !m_vs_prev;
    m_hs_prev = hs;
    m_vs_prev = vs;
    m_idx++;
    err = 0;
    if (he) begin
      hm = sat(m_idx - m_last_h);
      if (m_have_h) begin
        e_hm = 10'(hm);
        if (hm != HT) err = 1;
      end
      m_last_h = m_idx;
    end
    if (ve) begin
      vm = sat(m_lines + 1);
      if (m_have_v) begin
        e_vm = 10'(vm);
        if (vm != VT) err = 1;
      end
      m_lines = 0;
    end else if (he) begin
      m_lines++;
    end
    if (he) m_have_h = 1;
    if (ve) m_have_v = 1;
    if (err) begin
      m_st = 0; m_good = 0; m_have_h = 0; m_have_v = 0;
    end else if (ve) begin
      if (m_st == 0) begin
        m_st = 1; m_good = 0;
      end else if (m_st == 1) begin
        m_good++;
        if (m_good >= LF) m_st = 2;
      end
    end
    hc = sat(m_idx - m_last_h);
    vc = sat(m_lines);
    e_lock = (m_st == 2);
    e_err  = err;
    e_pix  = pixel;
    e_pv   = e_lock && hc >= HOFF && hc < HOFF + HA && vc >= VOFF && vc < VOFF + VA;
    e_fs   = e_pv && hc == HOFF && vc == VOFF;
    if (e_pv) begin
      e_x = 10'(hc - HOFF);
      e_y = 10'(vc - VOFF);
    end
  endtask

  task automatic check_all();
    check("a.x", a_x, e_x);         check("b.x", b_x, e_x);
    check("a.y", a_y, e_y);         check("b.y", b_y, e_y);
    check("a.valid", a_pv, e_pv);   check("b.valid", b_pv, e_pv);
    check("a.pixel", a_pix, e_pix); check("b.pixel", b_pix, e_pix);
    check("a.fstart", a_fs, e_fs);  check("b.fstart", b_fs, e_fs);
    check("a.locked", a_lock, e_lock); check("b.locked", b_lock, e_lock);
    check("a.err", a_err, e_err);   check("b.err", b_err, e_err);
    check("a.h_meas", a_hm, e_hm);  check("b.h_meas", b_hm, e_hm);
    check("a.v_meas", a_vm, e_vm);  check("b.v_meas", b_vm, e_vm);
  endtask

  // Raster generator; starts mid-frame.
  int hp = 10, lp = 5, cur_l = HT, cur_f = VT;
  bit perturb = 0, force_long = 0, force_plus = 0, rand_ce = 0, ce_tog = 0;

  task automatic gen_next();
    hsync = (hp < HS) ? 1'b0 : 1'b1;
    vsync = (lp < VS) ? 1'b0 : 1'b1;
    pixel = 3'($urandom);
    hp++;
    if (hp >= cur_l) begin
      hp = 0;
      lp++;
      if (lp >= cur_f) begin
        lp = 0;
        cur_f = (perturb && $urandom_range(0, 3) == 0) ? VT - 1 : VT;
      end
      if (force_long) begin
        cur_l = 1100; force_long = 0;
      end else if (force_plus) begin
        cur_l = HT + 1; force_plus = 0;
      end else begin
        cur_l = (perturb && $urandom_range(0, 29) == 0) ? HT + 1 : HT;
      end
    end
  endtask

  task automatic step();
    bit ce;
    if (rand_ce) ce = 1'($urandom_range(0, 1));
    else begin
      ce_tog = !ce_tog;
      ce = ce_tog;
    end
    pixel_ce = ce;
    if (ce) gen_next();
    @(posedge clk);
    model_update(ce);
    @(negedge clk);
    check_all();
    if (a_err) err_pulses++;
    if (a_fs) fs_seen++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_until_err(input int budget, output bit seen);
    int e0;
    e0 = err_pulses;
    seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      step();
      if (err_pulses != e0) seen = 1;
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  localparam int FRAME_CLKS = 2 * HT * VT;

  initial begin
    bit seen;
    int e0;
    #2;
    apply_reset();

    // Nominal stream, pixel_ce every second clock.
    run(4 * FRAME_CLKS);
    check("nom.locked", a_lock, 1);   check("nom.locked_inv", b_lock, 1);
    check("nom.h_meas", a_hm, HT);    check("nom.v_meas", a_vm, VT);

    // One line one pixel too long.
    e0 = err_pulses;
    force_plus = 1;
    run_until_err(400, seen);
    check("long1.seen", seen, 1);
    check("long1.h_meas", a_hm, HT + 1);
    check("long1.locked", a_lock, 0);
    run(4 * FRAME_CLKS);
    check("long1.pulses", err_pulses - e0, 1);
    check("relock", a_lock, 1);

    // Random perturbations and random pixel_ce.
    perturb = 1; rand_ce = 1;
    run(8000);
    perturb = 0; rand_ce = 0;

    // Mid-frame reset, then relock.
    run(FRAME_CLKS / 2 + 37);
    apply_reset();
    run(3 * FRAME_CLKS);
    check("rst.relock", a_lock, 1);

    // No hsync for 1100 pixels: counter saturates, error on next edge.
    force_long = 1;
    run_until_err(4000, seen);
    check("sat.seen", seen, 1);
    check("sat.h_meas", a_hm, 1023);
    check("sat.h_meas_inv", b_hm, 1023);
    run(4 * FRAME_CLKS);
    check("sat.relock", a_lock, 1);
    check("frames_seen", (fs_seen > 0) ? 1 : 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
